// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and defaults for the memory access sequencer
package mem_pkg;

    localparam int RAM_ADDR_W = 9;
    localparam logic [RAM_ADDR_W-1:0] DEF_IO_ADDR = 9'h1FF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDWAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CLS_RAM = 2'd0,
        CLS_IO  = 2'd1,
        CLS_ERR = 2'd2
    } cls_e;

endpackage

// File: rtl/mem_addr_decode.sv
// rtl/mem_addr_decode.sv - classifies a CPU address as RAM, I/O word or out-of-range
module mem_addr_decode
    import mem_pkg::*;
#(
    parameter int                ADDR_W  = RAM_ADDR_W,
    parameter logic [ADDR_W-1:0] IO_ADDR = DEF_IO_ADDR
) (
    input  logic [31:0]       req_addr,
    output cls_e              cls,
    output logic [ADDR_W-1:0] word_addr
);

    always_comb begin
        word_addr = req_addr[ADDR_W-1:0];
        // Out-of-range takes priority so a high-bit alias of IO_ADDR is an error.
        if (req_addr[31:ADDR_W] != '0) begin
            cls = CLS_ERR;
        end else if (req_addr[ADDR_W-1:0] == IO_ADDR) begin
            cls = CLS_IO;
        end else begin
            cls = CLS_RAM;
        end
    end

endmodule

// File: rtl/ram2.sv
// rtl/ram2.sv - 512x32 synchronous RAM with one-clock registered read
module ram2 #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    input  logic              write_enable,
    input  logic              read_enable,
    output logic [31:0]       data_out
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0] data_out_q;

    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[address] <= data_in;
        end
        if (read_enable) begin
            data_out_q <= mem[address];
        end
    end

    assign data_out = data_out_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store sequencer between CPU datapath, RAM and one I/O word
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int                ADDR_W    = RAM_ADDR_W,
    parameter logic [ADDR_W-1:0] IO_ADDR   = DEF_IO_ADDR,
    parameter logic [31:0]       OUT_RESET = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_data_in,
    output logic              ram_write_enable,
    output logic              ram_read_enable,
    input  logic [31:0]       ram_data_out,
    input  logic [31:0]       in_port,
    output logic [31:0]       out_port
);

    cls_e              dec_cls;
    logic [ADDR_W-1:0] dec_addr;

    mem_addr_decode #(
        .ADDR_W  (ADDR_W),
        .IO_ADDR (IO_ADDR)
    ) u_decode (
        .req_addr  (req_addr),
        .cls       (dec_cls),
        .word_addr (dec_addr)
    );

    state_e            state_q, state_d;
    cls_e              cls_q, cls_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [31:0]       ram_data_in_q, ram_data_in_d;
    logic              ram_we_q, ram_we_d;
    logic              ram_re_q, ram_re_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic [31:0]       out_port_q, out_port_d;

    // The RAM address/data registers double as the request latches.
    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        write_d       = write_q;
        ram_address_d = ram_address_q;
        ram_data_in_d = ram_data_in_q;
        resp_rdata_d  = resp_rdata_q;
        out_port_d    = out_port_q;
        ram_we_d      = 1'b0;
        ram_re_d      = 1'b0;
        resp_valid_d  = 1'b0;
        resp_err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    ram_address_d = dec_addr;
                    ram_data_in_d = req_wdata;
                    write_d       = req_write;
                    cls_d         = dec_cls;
                    ram_we_d      = req_write && (dec_cls == CLS_RAM);
                    ram_re_d      = !req_write && (dec_cls == CLS_RAM);
                    state_d       = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                case (cls_q)
                    CLS_RAM: begin
                        if (write_q) begin
                            resp_valid_d = 1'b1;
                            state_d      = ST_IDLE;
                        end else begin
                            state_d = ST_RDWAIT;
                        end
                    end
                    CLS_IO: begin
                        resp_valid_d = 1'b1;
                        state_d      = ST_IDLE;
                        if (write_q) begin
                            out_port_d = ram_data_in_q;
                        end else begin
                            resp_rdata_d = in_port;
                        end
                    end
                    default: begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        state_d      = ST_IDLE;
                    end
                endcase
            end
            ST_RDWAIT: begin
                resp_rdata_d = ram_data_out;
                resp_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cls_q         <= CLS_RAM;
            write_q       <= 1'b0;
            ram_address_q <= '0;
            ram_data_in_q <= 32'h0;
            ram_we_q      <= 1'b0;
            ram_re_q      <= 1'b0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= 32'h0;
            out_port_q    <= OUT_RESET;
        end else begin
            state_q       <= state_d;
            cls_q         <= cls_d;
            write_q       <= write_d;
            ram_address_q <= ram_address_d;
            ram_data_in_q <= ram_data_in_d;
            ram_we_q      <= ram_we_d;
            ram_re_q      <= ram_re_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_err_q    <= resp_err_d;
            resp_rdata_q  <= resp_rdata_d;
            out_port_q    <= out_port_d;
        end
    end

    assign req_ready        = req_ready_q;
    assign resp_valid       = resp_valid_q;
    assign resp_err         = resp_err_q;
    assign resp_rdata       = resp_rdata_q;
    assign ram_address      = ram_address_q;
    assign ram_data_in      = ram_data_in_q;
    assign ram_write_enable = ram_we_q;
    assign ram_read_enable  = ram_re_q;
    assign out_port         = out_port_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl with ram2
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [8:0]  ram_address;
    logic [31:0] ram_data_in;
    logic        ram_write_enable;
    logic        ram_read_enable;
    logic [31:0] ram_data_out;
    logic [31:0] in_port = 32'h0;
    logic [31:0] out_port;

    int n_cmp = 0;
    int n_bad = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int both_cnt = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_ready        (req_ready),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .ram_address      (ram_address),
        .ram_data_in      (ram_data_in),
        .ram_write_enable (ram_write_enable),
        .ram_read_enable  (ram_read_enable),
        .ram_data_out     (ram_data_out),
        .in_port          (in_port),
        .out_port         (out_port)
    );

    ram2 u_ram (
        .clk          (clk),
        .address      (ram_address),
        .data_in      (ram_data_in),
        .write_enable (ram_write_enable),
        .read_enable  (ram_read_enable),
        .data_out     (ram_data_out)
    );

    always @(negedge clk) begin
        if (ram_write_enable) we_cnt++;
        if (ram_read_enable) re_cnt++;
        if (ram_write_enable && ram_read_enable) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request from just after an edge; return latency in cycles (0 = timeout).
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, output int lat);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    int lat, we0, re0, nresp, nhs, last_resp, rdy_err, quiet;
    logic rdy_prev;
    logic [31:0] exp_q [3];

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_enables", {ram_write_enable, ram_read_enable}, 0);
        chk("rst_ram_address", ram_address, 0);
        chk("rst_ram_data_in", ram_data_in, 0);
        chk("rst_out_port", out_port, 0);

        // Preload word 104 via a store, then load it back.
        we0 = we_cnt; re0 = re_cnt;
        access(1'b1, 32'h68, 32'h55, lat);
        chk("st68_lat", lat, 1);
        chk("st68_we_pulses", we_cnt - we0, 1);
        chk("st68_re_pulses", re_cnt - re0, 0);
        chk("st68_err", resp_err, 0);
        chk("st68_ready", req_ready, 1);

        we0 = we_cnt; re0 = re_cnt;
        access(1'b0, 32'h68, 32'h0, lat);
        chk("ld68_lat", lat, 2);
        chk("ld68_rdata", resp_rdata, 32'h55);
        chk("ld68_err", resp_err, 0);
        chk("ld68_re_pulses", re_cnt - re0, 1);
        chk("ld68_we_pulses", we_cnt - we0, 0);
        @(posedge clk); #1;
        chk("ld68_pulse_width", resp_valid, 0);

        access(1'b1, 32'h52, 32'h2F, lat);
        chk("st52_lat", lat, 1);
        access(1'b0, 32'h52, 32'h0, lat);
        chk("ld52_lat", lat, 2);
        chk("ld52_rdata", resp_rdata, 32'h2F);

        we0 = we_cnt; re0 = re_cnt;
        access(1'b1, 32'h1FF, 32'hDEADBEEF, lat);
        chk("io_st_lat", lat, 1);
        chk("io_st_out_port", out_port, 32'hDEADBEEF);
        chk("io_st_enables", (we_cnt - we0) + (re_cnt - re0), 0);
        chk("io_st_rdata_kept", resp_rdata, 32'h2F);

        in_port = 32'h12345678;
        we0 = we_cnt; re0 = re_cnt;
        access(1'b0, 32'h1FF, 32'h0, lat);
        chk("io_ld_lat", lat, 1);
        chk("io_ld_rdata", resp_rdata, 32'h12345678);
        chk("io_ld_enables", (we_cnt - we0) + (re_cnt - re0), 0);
        chk("io_ld_err", resp_err, 0);

        we0 = we_cnt; re0 = re_cnt;
        access(1'b0, 32'h00000200, 32'h0, lat);
        chk("err_ld_lat", lat, 1);
        chk("err_ld_err", resp_err, 1);
        chk("err_ld_rdata_kept", resp_rdata, 32'h12345678);
        chk("err_ld_enables", (we_cnt - we0) + (re_cnt - re0), 0);
        @(posedge clk); #1;
        chk("err_pulse_width", {resp_valid, resp_err}, 0);

        we0 = we_cnt;
        access(1'b1, 32'h800001FF, 32'h00000BAD, lat);
        chk("err_st_lat", lat, 1);
        chk("err_st_err", resp_err, 1);
        chk("err_st_out_port", out_port, 32'hDEADBEEF);
        chk("err_st_we_pulses", we_cnt - we0, 0);

        access(1'b1, 32'h10, 32'hA0, lat);
        access(1'b1, 32'h11, 32'hA1, lat);
        access(1'b1, 32'h12, 32'hA2, lat);
        chk("b2b_prep_err", resp_err, 0);

        // Back-to-back loads with req_valid held; expect handshakes on E0, E3, E6.
        exp_q[0] = 32'hA0; exp_q[1] = 32'hA1; exp_q[2] = 32'hA2;
        nresp = 0; nhs = 0; last_resp = 0; rdy_err = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
        rdy_prev = req_ready;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            #1;
            if (rdy_prev && req_valid) begin
                nhs++;
                if (nhs < 3) req_addr = 32'h10 + nhs;
                else req_valid = 1'b0;
            end
            if (req_ready != resp_valid) rdy_err++;
            if (resp_valid) begin
                if (nresp < 3) chk("b2b_rdata", resp_rdata, exp_q[nresp]);
                nresp++;
                last_resp = i;
            end
            rdy_prev = req_ready;
        end
        req_valid = 1'b0;
        chk("b2b_handshakes", nhs, 3);
        chk("b2b_responses", nresp, 3);
        chk("b2b_last_resp_cycle", last_resp, 9);
        chk("b2b_ready_vs_resp", rdy_err, 0);

        // Reset while waiting on RAM read data.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h52;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rdwait_ready_low", req_ready, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_mid_resp_valid", resp_valid, 0);
        chk("rst_mid_ready", req_ready, 1);
        chk("rst_mid_out_port", out_port, 32'h0);
        chk("rst_mid_enables", {ram_write_enable, ram_read_enable}, 0);
        quiet = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (resp_valid) quiet++;
        end
        chk("rst_mid_no_resp", quiet, 0);

        access(1'b0, 32'h68, 32'h0, lat);
        chk("post_rst_lat", lat, 2);
        chk("post_rst_rdata", resp_rdata, 32'h55);
        chk("never_both_enables", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory access sequencer between the CPU datapath (MAR/MDR and control unit) and the 512x32 synchronous RAM.
- Accepts one load/store request at a time and drives the RAM address, data, read_enable and write_enable. The RAM has a one-clock registered read; this block absorbs that latency and returns a registered response.
- Decodes one memory-mapped I/O word: stores to it update an output port, and loads from it return a sampled input port.
- Flags out-of-range addresses without touching the RAM.

Parameters:
- ADDR_W, 9, RAM address width (512 words).
- IO_ADDR, 9'h1FF, word address of the memory-mapped I/O register.
- OUT_RESET, 32'h0, reset value of out_port.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  control unit requests an access.
- req_write  in  1  1 = store, 0 = load; sampled with req_valid.
- req_addr  in  32  MAR value.
- req_wdata  in  32  MDR value for stores.
- req_ready  out  1  high only in IDLE; handshake occurs when req_valid && req_ready at a posedge.
- resp_valid  out  1  one-cycle pulse: the access has completed.
- resp_rdata  out  32  load data; held until the next load response.
- resp_err  out  1  qualifies resp_valid: the address was out of range.
- ram_address  out  ADDR_W  to RAM address.
- ram_data_in  out  32  to RAM write data.
- ram_write_enable  out  1  to RAM.
- ram_read_enable  out  1  to RAM.
- ram_data_out  in  32  from RAM registered read data.
- in_port  in  32  external input word.
- out_port  out  32  external output register.

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; ram_write_enable=0; ram_read_enable=0; ram_address=0; ram_data_in=0; out_port=OUT_RESET.
- Reset mid-access aborts the access, and no response is produced. A RAM write already clocked at the same edge is not undone.
- States:
  - IDLE
  - ACCESS
  - RDWAIT
- On handshake (edge E0) the block latches addr[ADDR_W-1:0], wdata and write. It classifies the request:
  - err: req_addr[31:ADDR_W] != 0
  - io: low bits == IO_ADDR
  - ram: otherwise
- IDLE -> ACCESS on handshake. req_ready=0 in every state except IDLE, and req_valid is ignored there.
- ACCESS, ram class: ram_address and ram_data_in are driven from the latches.
  - Store: ram_write_enable=1 for exactly this cycle; the RAM writes at E1. At E1, resp_valid<=1, state->IDLE.
  - Load: ram_read_enable=1 for exactly this cycle; the RAM registers data at E1. State->RDWAIT.
- RDWAIT: at E2, resp_rdata<=ram_data_out, resp_valid<=1, state->IDLE.
- Latency from handshake edge to resp_valid high: store 1 cycle, RAM load 2 cycles.
- ACCESS, io class: no RAM enables. At E1, resp_valid<=1, state->IDLE.
  - Store: out_port<=wdata.
  - Load: resp_rdata<=in_port (sampled at E1).
- ACCESS, err class: no RAM enables, no out_port change. At E1, resp_valid<=1, resp_err<=1, resp_rdata unchanged, state->IDLE.
- resp_valid and resp_err are high for exactly one cycle. resp_err is 0 on every non-error response.
- Back-to-back: req_ready is high in the same cycle as resp_valid, so the next handshake can occur at that edge. Minimum spacing is 2 edges for stores and 3 edges for RAM loads.
- Read and write enables are never asserted together. Both are 0 outside ACCESS.

Decomposition:
- Shared package mem_pkg holds:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, RDWAIT=2'd2)
  - class encoding (CLS_RAM, CLS_IO, CLS_ERR)
  - RAM_ADDR_W=9
  - default IO_ADDR
- One natural sub-module: mem_addr_decode, purely combinational (req_addr -> class, word address).
- The FSM, latches and out_port stay in mem_access_ctrl.
- Bench top instantiates mem_access_ctrl with ram2 so that real RAM latency is exercised.

Test Plan:
- Load with RAM word 104=32'h55: req addr 32'h68, write=0 -> ram_read_enable for one cycle; resp_valid 2 cycles after handshake; resp_rdata=32'h55; resp_err=0.
- Store then load: store addr 32'h52 data 32'h2F, then load 32'h52 -> store resp 1 cycle after handshake with ram_write_enable pulsed once; load returns 32'h2F.
- I/O: store 32'h1FF data 32'hDEADBEEF -> out_port=32'hDEADBEEF and no RAM enable. Then load 32'h1FF with in_port=32'h12345678 -> resp_rdata=32'h12345678.
- Error: load 32'h00000200 -> resp_valid and resp_err in the same cycle 1 cycle after handshake; no RAM enables; resp_rdata keeps its previous value.
- Back-to-back: req_valid held high with 3 queued loads -> each accepted the cycle resp_valid rises; req_ready low during ACCESS and RDWAIT; 3 correct responses in 9 cycles.
- Reset in RDWAIT: assert reset for one cycle -> no resp_valid, req_ready=1 next cycle, out_port=0, all RAM enables 0.
